ctrl_sequencer: RTL and testbench

- Hardwired control unit sitting directly upstream of datapath.
- Steps through fetch (T0–T2) and execute (T3–T6) states and drives every register-enable, tristate-out, memory-read, IncPC and ALU opcode strobe of datapath, one state per clock.
- Decodes the instruction word that datapath's IR holds.
- Covers three-register ALU ops, mul/div (HI/LO writeback), nop and halt.

---
 rtl/ctrl_sequencer_if.sv | 44 ++++
 rtl/ctrl_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_sequencer_if.sv
// Strobe/handshake bundle between the hardwired control sequencer and the datapath.
// The master drives every strobe; the slave (datapath side) supplies Run and IR.
interface ctrl_sequencer_if #(
    parameter int ICOUNT_W = 16
);
    logic                Run;
    logic [31:0]         IR;
    logic [15:0]         Rin;
    logic [15:0]         Rout;
    logic                HIin;
    logic                LOin;
    logic                Yin;
    logic                Zin;
    logic                PCin;
    logic                IRin;
    logic                MARin;
    logic                MDRin;
    logic                HIout;
    logic                LOout;
    logic                Zhighout;
    logic                Zlowout;
    logic                PCout;
    logic                MDRout;
    logic                Read;
    logic                IncPC;
    logic [4:0]          opcode;
    logic                Done;
    logic                Halted;
    logic [ICOUNT_W-1:0] icount;

    modport master (
        input  Run, IR,
        output Rin, Rout, HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin,
               HIout, LOout, Zhighout, Zlowout, PCout, MDRout,
               Read, IncPC, opcode, Done, Halted, icount
    );

    modport slave (
        output Run, IR,
        input  Rin, Rout, HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin,
               HIout, LOout, Zhighout, Zlowout, PCout, MDRout,
               Read, IncPC, opcode, Done, Halted, icount
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// Hardwired Moore control unit: fetch (T0-T2) and execute (T3-T6) sequencing of the
// datapath strobes, with a variable-length memory wait in T1 and a retired-instruction count.
module ctrl_sequencer #(
    parameter int MEM_WAIT = 0,
    parameter int ICOUNT_W = 16
) (
    input  logic              Clock,
    input  logic              clear,
    ctrl_sequencer_if.master  bus
);

    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, HALTED
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU, CLS_MULDIV, CLS_NOP, CLS_HALT
    } iclass_t;

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    state_t              state, state_nxt;
    logic [2:0]          wait_cnt, wait_nxt;
    logic [ICOUNT_W-1:0] icount_q;
    logic                done;
    logic [4:0]          op;
    logic [3:0]          ra, rb, rc;
    iclass_t             iclass;
    logic                unused_ir_low;

    function automatic logic [15:0] reg_sel(input logic [3:0] idx);
        reg_sel = 16'h0001 << idx;
    endfunction

    assign op            = bus.IR[31:27];
    assign ra            = bus.IR[26:23];
    assign rb            = bus.IR[22:19];
    assign rc            = bus.IR[18:15];
    assign unused_ir_low = ^bus.IR[14:0];

    always_comb begin
        if (op <= 5'd14)                    iclass = CLS_ALU;
        else if (op == 5'd15 || op == 5'd16) iclass = CLS_MULDIV;
        else if (op == 5'd26)               iclass = CLS_HALT;
        else                                iclass = CLS_NOP;
    end

    always_ff @(posedge Clock) begin
        if (clear) begin
            state    <= IDLE;
            wait_cnt <= 3'd0;
            icount_q <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            // Retirement coincides with the Done cycle, including entry to HALTED.
            if (done)
                icount_q <= icount_q + 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_nxt     = wait_cnt;
        done         = 1'b0;
        bus.Rin      = 16'h0000;
        bus.Rout     = 16'h0000;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.Zin      = 1'b0;
        bus.PCin     = 1'b0;
        bus.IRin     = 1'b0;
        bus.MARin    = 1'b0;
        bus.MDRin    = 1'b0;
        bus.HIout    = 1'b0;
        bus.LOout    = 1'b0;
        bus.Zhighout = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.PCout    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.Read     = 1'b0;
        bus.IncPC    = 1'b0;
        bus.opcode   = 5'b00000;

        case (state)
            IDLE: begin
                if (bus.Run) state_nxt = T0;
            end
            T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
                wait_nxt  = 3'd0;
                state_nxt = T1;
            end
            T1: begin
                bus.Read = 1'b1;
                // Read is held for MEM_WAIT extra cycles; MDR captures only on the last one.
                if (wait_cnt == WAIT_LAST) begin
                    bus.Zlowout = 1'b1;
                    bus.PCin    = 1'b1;
                    bus.MDRin   = 1'b1;
                    wait_nxt    = 3'd0;
                    state_nxt   = T2;
                end else begin
                    wait_nxt = wait_cnt + 3'd1;
                end
            end
            T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                state_nxt  = T3;
            end
            T3: begin
                case (iclass)
                    CLS_ALU: begin
                        bus.Rout  = reg_sel(rb);
                        bus.Yin   = 1'b1;
                        state_nxt = T4;
                    end
                    CLS_MULDIV: begin
                        bus.Rout  = reg_sel(ra);
                        bus.Yin   = 1'b1;
                        state_nxt = T4;
                    end
                    CLS_HALT: begin
                        done      = 1'b1;
                        state_nxt = HALTED;
                    end
                    default: begin
                        done      = 1'b1;
                        state_nxt = bus.Run ? T0 : IDLE;
                    end
                endcase
            end
            T4: begin
                if (iclass == CLS_ALU) begin
                    bus.Rout   = reg_sel(rc);
                    bus.Zin    = 1'b1;
                    bus.opcode = op;
                end else if (iclass == CLS_MULDIV) begin
                    bus.Rout   = reg_sel(rb);
                    bus.Zin    = 1'b1;
                    bus.opcode = op;
                end
                state_nxt = T5;
            end
            T5: begin
                if (iclass == CLS_MULDIV) begin
                    bus.Zlowout = 1'b1;
                    bus.LOin    = 1'b1;
                    state_nxt   = T6;
                end else begin
                    if (iclass == CLS_ALU) begin
                        bus.Zlowout = 1'b1;
                        bus.Rin     = reg_sel(ra);
                    end
                    done      = 1'b1;
                    state_nxt = bus.Run ? T0 : IDLE;
                end
            end
            T6: begin
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
                done         = 1'b1;
                state_nxt    = bus.Run ? T0 : IDLE;
            end
            HALTED: begin
                state_nxt = HALTED;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.Done   = done;
    assign bus.Halted = (state == HALTED);
    assign bus.icount = icount_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: two instances (MEM_WAIT=0 / 16-bit count, MEM_WAIT=3 / 2-bit count)
// against a per-cycle positional model, plus directed literal checks on the first instance.
module tb_ctrl_sequencer;

    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic hi_in, lo_in, y_in, z_in, pc_in, ir_in, mar_in, mdr_in;
        logic hi_out, lo_out, zh_out, zl_out, pc_out, mdr_out, read, inc_pc;
        logic [4:0] opcode;
        logic done;
        logic halted;
    } strobes_t;

    logic        Clock;
    logic        clear;
    logic        run, run3;
    logic [31:0] ir, ir3;

    int checks = 0;
    int errors = 0;

    ctrl_sequencer_if #(.ICOUNT_W(16)) bus0 ();
    ctrl_sequencer_if #(.ICOUNT_W(2))  bus3 ();

    assign bus0.Run = run;
    assign bus0.IR  = ir;
    assign bus3.Run = run3;
    assign bus3.IR  = ir3;

    ctrl_sequencer #(.MEM_WAIT(0), .ICOUNT_W(16)) dut0 (
        .Clock (Clock),
        .clear (clear),
        .bus   (bus0)
    );

    ctrl_sequencer #(.MEM_WAIT(3), .ICOUNT_W(2)) dut3 (
        .Clock (Clock),
        .clear (clear),
        .bus   (bus3)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    strobes_t    obs [2];
    logic [15:0] icnt_obs [2];

    assign obs[0] = {bus0.Rin, bus0.Rout, bus0.HIin, bus0.LOin, bus0.Yin, bus0.Zin,
                     bus0.PCin, bus0.IRin, bus0.MARin, bus0.MDRin, bus0.HIout, bus0.LOout,
                     bus0.Zhighout, bus0.Zlowout, bus0.PCout, bus0.MDRout, bus0.Read,
                     bus0.IncPC, bus0.opcode, bus0.Done, bus0.Halted};
    assign obs[1] = {bus3.Rin, bus3.Rout, bus3.HIin, bus3.LOin, bus3.Yin, bus3.Zin,
                     bus3.PCin, bus3.IRin, bus3.MARin, bus3.MDRin, bus3.HIout, bus3.LOout,
                     bus3.Zhighout, bus3.Zlowout, bus3.PCout, bus3.MDRout, bus3.Read,
                     bus3.IncPC, bus3.opcode, bus3.Done, bus3.Halted};
    assign icnt_obs[0] = bus0.icount;
    assign icnt_obs[1] = {14'd0, bus3.icount};

    // ---------------- behavioural model ----------------
    // pos = cycle offset inside the current instruction (0 = first fetch cycle), -1 = idle.
    int          pos  [2];
    bit          hlt  [2];
    int unsigned icm  [2];
    bit          armed = 1'b0;
    int          mw   [2] = '{0, 3};
    int unsigned wmask[2] = '{32'hFFFF, 32'h3};

    // 0 = ALU, 1 = MULDIV, 2 = NOP, 3 = HALT
    function automatic int cls_of(input logic [31:0] i);
        int o;
        o = int'(i[31:27]);
        if (o <= 14)             return 0;
        if (o == 15 || o == 16)  return 1;
        if (o == 26)             return 3;
        return 2;
    endfunction

    function automatic int exec_len(input int cls);
        if (cls == 0) return 3;
        if (cls == 1) return 4;
        return 1;
    endfunction

    function automatic strobes_t model_exp(input int p, input bit h, input int w,
                                           input logic [31:0] i);
        strobes_t e;
        int       k, cls;
        e   = '0;
        cls = cls_of(i);
        if (h) begin
            e.halted = 1'b1;
        end else if (p == 0) begin
            e.pc_out = 1'b1; e.mar_in = 1'b1; e.inc_pc = 1'b1; e.z_in = 1'b1;
        end else if (p >= 1 && p <= w + 1) begin
            e.read = 1'b1;
            if (p == w + 1) begin
                e.zl_out = 1'b1; e.pc_in = 1'b1; e.mdr_in = 1'b1;
            end
        end else if (p == w + 2) begin
            e.mdr_out = 1'b1; e.ir_in = 1'b1;
        end else if (p > w + 2) begin
            k = p - (w + 3);
            if (k == 0) begin
                if (cls == 0)      begin e.rout = 16'h1 << i[22:19]; e.y_in = 1'b1; end
                else if (cls == 1) begin e.rout = 16'h1 << i[26:23]; e.y_in = 1'b1; end
                else               e.done = 1'b1;
            end else if (k == 1) begin
                e.rout   = (cls == 0) ? (16'h1 << i[18:15]) : (16'h1 << i[22:19]);
                e.z_in   = 1'b1;
                e.opcode = i[31:27];
            end else if (k == 2) begin
                e.zl_out = 1'b1;
                if (cls == 0) begin e.rin = 16'h1 << i[26:23]; e.done = 1'b1; end
                else          e.lo_in = 1'b1;
            end else if (k == 3) begin
                e.zh_out = 1'b1; e.hi_in = 1'b1; e.done = 1'b1;
            end
        end
        return e;
    endfunction

    always @(posedge Clock) begin
        if (clear) armed <= 1'b1;
        for (int d = 0; d < 2; d++) begin
            logic [31:0] iv;
            logic        rv;
            iv = (d == 0) ? ir : ir3;
            rv = (d == 0) ? run : run3;
            if (clear) begin
                pos[d] <= -1;
                hlt[d] <= 1'b0;
                icm[d] <= 0;
            end else if (!hlt[d]) begin
                if (pos[d] < 0) begin
                    if (rv) pos[d] <= 0;
                end else if (pos[d] == mw[d] + 3 + exec_len(cls_of(iv)) - 1) begin
                    icm[d] <= (icm[d] + 1) & wmask[d];
                    if (cls_of(iv) == 3) hlt[d] <= 1'b1;
                    else                 pos[d] <= rv ? 0 : -1;
                end else begin
                    pos[d] <= pos[d] + 1;
                end
            end
        end
    end

    always @(negedge Clock) begin
        if (armed) begin
            for (int d = 0; d < 2; d++) begin
                strobes_t e;
                e = model_exp(pos[d], hlt[d], mw[d], (d == 0) ? ir : ir3);
                checks++;
                if (obs[d] !== e) begin
                    errors++;
                    $display("FAIL model_strobes dut%0d t=%0t: got %h expected %h",
                             d, $time, obs[d], e);
                end
                checks++;
                if (icnt_obs[d] !== 16'(icm[d])) begin
                    errors++;
                    $display("FAIL model_icount dut%0d t=%0t: got %0d expected %0d",
                             d, $time, icnt_obs[d], icm[d]);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin
        strobes_t hq;
        hq        = '0;
        hq.halted = 1'b1;

        clear = 1'b1; run = 1'b0; run3 = 1'b0;
        ir  = 32'h8118_0000;
        ir3 = 32'h8118_0000;
        cycles(2);
        clear = 1'b0; run = 1'b1; run3 = 1'b1;
        chk("reset_idle_strobes", 64'(obs[0]), 64'h0);
        chk("reset_icount", 64'(bus0.icount), 64'h0);

        // div R2,R3 followed by an ALU op, back to back
        for (int c = 1; c <= 18; c++) begin
            cyc();
            if (c >= 2 && c <= 5) begin
                chk("mw3_read", 64'(bus3.Read), 64'h1);
                chk("mw3_mdrin", 64'(bus3.MDRin), 64'(c == 5));
                chk("mw3_pcin", 64'(bus3.PCin), 64'(c == 5));
            end
            if (c == 1)  chk("div_t0_pcout", 64'(bus0.PCout), 64'h1);
            if (c == 4)  begin chk("div_t3_rout", 64'(bus0.Rout), 64'h4);
                               chk("div_t3_yin", 64'(bus0.Yin), 64'h1); end
            if (c == 5)  begin chk("div_t4_rout", 64'(bus0.Rout), 64'h8);
                               chk("div_t4_opcode", 64'(bus0.opcode), 64'h10);
                               chk("div_t4_zin", 64'(bus0.Zin), 64'h1); end
            if (c == 6)  begin chk("div_t5_lo", 64'({bus0.Zlowout, bus0.LOin, bus0.Done}), 64'h6);
                               chk("mw3_t2_read", 64'(bus3.Read), 64'h0); end
            if (c == 7)  begin chk("div_t6_hi", 64'({bus0.Zhighout, bus0.HIin, bus0.Done}), 64'h7);
                               chk("div_t6_icount", 64'(bus0.icount), 64'h0); end
            if (c == 8)  begin chk("div_retired", 64'(bus0.icount), 64'h1);
                               chk("alu_t0_pcout", 64'(bus0.PCout), 64'h1);
                               ir = 32'h1A20_0000; end
            if (c == 10) chk("mw3_div_done", 64'(bus3.Done), 64'h1);
            if (c == 11) chk("alu_t3_rout", 64'(bus0.Rout), 64'h10);
            if (c == 12) begin chk("alu_t4_rout", 64'(bus0.Rout), 64'h1);
                               chk("alu_t4_opcode", 64'(bus0.opcode), 64'h3); end
            if (c == 13) begin chk("alu_t5_rin", 64'(bus0.Rin), 64'h10);
                               chk("alu_t5_done", 64'(bus0.Done), 64'h1); end
            if (c == 14) begin chk("alu_b2b_pcout", 64'(bus0.PCout), 64'h1);
                               chk("alu_icount", 64'(bus0.icount), 64'h2); end
            if (c == 18) chk("alu2_t4_opcode", 64'(bus0.opcode), 64'h3);
        end

        // clear in the middle of T4
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("clear_mid_strobes", 64'(obs[0]), 64'h0);
        chk("clear_mid_icount", 64'(bus0.icount), 64'h0);
        cyc();
        chk("clear_resume_t0", 64'(bus0.PCout), 64'h1);

        // NOP then HALT
        ir = 32'hF800_0000;
        cycles(3);
        chk("nop_t3_done", 64'(bus0.Done), 64'h1);
        chk("nop_t3_rout", 64'(bus0.Rout), 64'h0);
        cyc();
        chk("nop_icount", 64'(bus0.icount), 64'h1);
        ir = 32'hD000_0000;
        cycles(3);
        chk("halt_t3_done", 64'({bus0.Done, bus0.Halted}), 64'h2);
        cyc();
        chk("halt_entered", 64'(bus0.Halted), 64'h1);
        chk("halt_icount", 64'(bus0.icount), 64'h2);
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("halt_quiet", 64'(obs[0]), 64'(hq));
        end
        chk("halt_icount_hold", 64'(bus0.icount), 64'h2);
        clear = 1'b1; run = 1'b0;
        cyc();
        clear = 1'b0;
        chk("unhalt_halted", 64'(bus0.Halted), 64'h0);
        chk("unhalt_icount", 64'(bus0.icount), 64'h0);
        cyc();
        chk("unhalt_idle", 64'(obs[0]), 64'h0);

        // mul R1,R2 with Run dropped in T4
        ir  = 32'h7890_0000;
        run = 1'b1;
        cyc();
        chk("mul_t0_pcout", 64'(bus0.PCout), 64'h1);
        cycles(3);
        chk("mul_t3_rout", 64'(bus0.Rout), 64'h2);
        cyc();
        chk("mul_t4_rout", 64'(bus0.Rout), 64'h4);
        chk("mul_t4_opcode", 64'(bus0.opcode), 64'h0F);
        run = 1'b0;
        cyc();
        chk("mul_t5_loin", 64'(bus0.LOin), 64'h1);
        cyc();
        chk("mul_t6_done", 64'({bus0.HIin, bus0.Done}), 64'h3);
        cyc();
        chk("mul_idle_strobes", 64'(obs[0]), 64'h0);
        chk("mul_icount", 64'(bus0.icount), 64'h1);
        cyc();
        chk("mul_idle_hold", 64'(obs[0]), 64'h0);
        run = 1'b1;
        cyc();
        chk("rerun_t0", 64'(bus0.PCout), 64'h1);

        // let the MEM_WAIT=3 instance wrap its 2-bit counter a few times
        cycles(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
